// File: rtl/exibidor_sequencia.sv
// exibidor_sequencia: shows a latched word of four 2-bit indices as a timed
// one-hot LED sequence (T_ON lit cycles, T_OFF dark cycles per item), then
// pulses fim once. abortar cancels at any time. All outputs are registered.
module exibidor_sequencia #(
  parameter int T_ON  = 500,
  parameter int T_OFF = 250
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [7:0] indices,
  input  logic       abortar,
  output logic [3:0] leds,
  output logic       ocupado,
  output logic       fim,
  output logic [2:0] db_estado,
  output logic [1:0] db_item
);

  // The cycle counter only has to reach max(T_ON,T_OFF)-1, never beyond.
  localparam int T_MAX = (T_ON > T_OFF) ? T_ON : T_OFF;
  localparam int CW    = (T_MAX <= 2) ? 1 : $clog2(T_MAX);
  localparam logic [CW-1:0] ON_LAST  = CW'(T_ON - 1);
  localparam logic [CW-1:0] OFF_LAST = CW'(T_OFF - 1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_UM   = CW'(1);

  typedef enum logic [2:0] {
    OCIOSO = 3'd0,
    ACENDE = 3'd1,
    APAGA  = 3'd2,
    FIM    = 3'd3
  } estado_t;

  estado_t         estado_r, estado_s;
  logic [CW-1:0]   cnt_r, cnt_s;
  logic [1:0]      item_r, item_s;
  logic [7:0]      palavra_r, palavra_s;
  logic [3:0]      leds_r, leds_s;
  logic            ocupado_r, ocupado_s;
  logic            fim_r, fim_s;

  // One-hot LED pattern for item 'item' of the latched word.
  function automatic logic [3:0] decodifica(input logic [7:0] palavra,
                                            input logic [1:0] item);
    logic [1:0] idx;
    idx = palavra[{item, 1'b0} +: 2];
    case (idx)
      2'd0:    decodifica = 4'b0001;
      2'd1:    decodifica = 4'b0010;
      2'd2:    decodifica = 4'b0100;
      2'd3:    decodifica = 4'b1000;
      default: decodifica = 4'b0000;
    endcase
  endfunction

  // Next-state, counters and next values of the registered outputs.
  always_comb begin
    estado_s  = estado_r;
    cnt_s     = cnt_r;
    item_s    = item_r;
    palavra_s = palavra_r;
    if (abortar) begin
      estado_s = OCIOSO;
      cnt_s    = CNT_ZERO;
      item_s   = 2'd0;
    end else begin
      case (estado_r)
        OCIOSO: begin
          if (iniciar) begin
            palavra_s = indices;
            cnt_s     = CNT_ZERO;
            item_s    = 2'd0;
            estado_s  = ACENDE;
          end else begin
            estado_s = OCIOSO;
          end
        end
        ACENDE: begin
          if (cnt_r == ON_LAST) begin
            cnt_s    = CNT_ZERO;
            estado_s = APAGA;
          end else begin
            cnt_s = cnt_r + CNT_UM;
          end
        end
        APAGA: begin
          if (cnt_r == OFF_LAST) begin
            cnt_s = CNT_ZERO;
            // Last item ends the sequence instead of wrapping the item counter.
            if (item_r == 2'd3) begin
              estado_s = FIM;
            end else begin
              item_s   = item_r + 2'd1;
              estado_s = ACENDE;
            end
          end else begin
            cnt_s = cnt_r + CNT_UM;
          end
        end
        FIM: begin
          estado_s = OCIOSO;
        end
        default: begin
          estado_s = OCIOSO;
          cnt_s    = CNT_ZERO;
          item_s   = 2'd0;
        end
      endcase
    end

    // Outputs are computed from next state so they can be registered with it.
    if (estado_s == ACENDE) begin
      leds_s = decodifica(palavra_s, item_s);
    end else begin
      leds_s = 4'b0000;
    end
    ocupado_s = (estado_s != OCIOSO);
    fim_s     = (estado_s == FIM);
  end

  // State, counters, latched word and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_r  <= OCIOSO;
      cnt_r     <= CNT_ZERO;
      item_r    <= 2'd0;
      palavra_r <= 8'd0;
      leds_r    <= 4'b0000;
      ocupado_r <= 1'b0;
      fim_r     <= 1'b0;
    end else begin
      estado_r  <= estado_s;
      cnt_r     <= cnt_s;
      item_r    <= item_s;
      palavra_r <= palavra_s;
      leds_r    <= leds_s;
      ocupado_r <= ocupado_s;
      fim_r     <= fim_s;
    end
  end

  assign leds      = leds_r;
  assign ocupado   = ocupado_r;
  assign fim       = fim_r;
  assign db_estado = estado_r;
  assign db_item   = item_r;

endmodule

// File: tb/tb_exibidor_sequencia.sv
// Bench for exibidor_sequencia: a T_ON=3/T_OFF=2 instance driven through the
// scenarios, plus a default-parameter instance for the long sequence.
module tb_exibidor_sequencia;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       iniciar = 1'b0;
  logic [7:0] indices = 8'd0;
  logic       abortar = 1'b0;
  logic [3:0] leds;
  logic       ocupado, fim;
  logic [2:0] db_estado;
  logic [1:0] db_item;

  logic       iniciar_d = 1'b0;
  logic [7:0] indices_d = 8'd0;
  logic       abortar_d = 1'b0;
  logic [3:0] leds_d;
  logic       ocupado_d, fim_d;
  logic [2:0] db_estado_d;
  logic [1:0] db_item_d;

  int n_cmp = 0;
  int n_err = 0;

  exibidor_sequencia #(.T_ON(3), .T_OFF(2)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .indices(indices),
    .abortar(abortar), .leds(leds), .ocupado(ocupado), .fim(fim),
    .db_estado(db_estado), .db_item(db_item)
  );

  exibidor_sequencia dut_d (
    .clock(clock), .reset(reset), .iniciar(iniciar_d), .indices(indices_d),
    .abortar(abortar_d), .leds(leds_d), .ocupado(ocupado_d), .fim(fim_d),
    .db_estado(db_estado_d), .db_item(db_item_d)
  );

  always #5 clock = ~clock;

  // Expected outputs in cycle t after the start edge, from the timing rules.
  function automatic void exp_at(input int t, input int ton, input int toff,
                                 input logic [7:0] w, output logic [3:0] l,
                                 output logic oc, output logic f,
                                 output logic [2:0] st, output logic [1:0] it);
    int per, p, r;
    logic [1:0] id;
    per = ton + toff;
    l = 4'b0000; oc = 1'b0; f = 1'b0; st = 3'd0; it = 2'd0;
    if (t >= 1 && t <= 4 * per) begin
      p  = (t - 1) / per;
      r  = (t - 1) % per;
      oc = 1'b1;
      it = p[1:0];
      if (r < ton) begin
        id = w[2*p +: 2];
        l  = 4'b0001 << id;
        st = 3'd1;
      end else begin
        st = 3'd2;
      end
    end else if (t == 4 * per + 1) begin
      oc = 1'b1; f = 1'b1; st = 3'd3; it = 2'd3;
    end
  endfunction

  // Run one sequence from a negedge; scr: 0 none, 1 indices=FF, 2 random.
  task automatic play(input logic [7:0] w, input int scr, input bit repulse,
                      input string nm);
    logic [3:0] el; logic eo, ef; logic [2:0] es; logic [1:0] ei;
    indices = w; iniciar = 1'b1;
    @(negedge clock); iniciar = 1'b0;
    for (int t = 1; t <= 22; t++) begin
      exp_at(t, 3, 2, w, el, eo, ef, es, ei);
      n_cmp++; if (leds !== el) begin n_err++; $display("FAIL %s leds t=%0d got %b exp %b", nm, t, leds, el); end
      n_cmp++; if (ocupado !== eo) begin n_err++; $display("FAIL %s ocupado t=%0d got %b exp %b", nm, t, ocupado, eo); end
      n_cmp++; if (fim !== ef) begin n_err++; $display("FAIL %s fim t=%0d got %b exp %b", nm, t, fim, ef); end
      n_cmp++; if (db_estado !== es) begin n_err++; $display("FAIL %s db_estado t=%0d got %0d exp %0d", nm, t, db_estado, es); end
      if (t <= 21) begin
        n_cmp++; if (db_item !== ei) begin n_err++; $display("FAIL %s db_item t=%0d got %0d exp %0d", nm, t, db_item, ei); end
      end
      if (scr == 1) indices = 8'hFF;
      else if (scr == 2) indices = 8'($urandom);
      iniciar = repulse && (t == 5 || t == 21);
      if (t < 22) @(negedge clock);
    end
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    #1;
    n_cmp++; if ({leds, ocupado, fim, db_estado, db_item} !== 11'd0) begin n_err++; $display("FAIL reset_hold got %b exp 0", {leds, ocupado, fim, db_estado, db_item}); end
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (3) begin
      @(negedge clock);
      n_cmp++; if ({leds, ocupado, fim, db_estado, db_item} !== 11'd0) begin n_err++; $display("FAIL reset_idle got %b exp 0", {leds, ocupado, fim, db_estado, db_item}); end
    end
  endtask

  task automatic test_basic();
    play(8'b11_10_01_00, 0, 1'b0, "basic");
    @(negedge clock);
  endtask

  task automatic test_repeat_mask();
    play(8'h00, 1, 1'b0, "repeat_mask");
    @(negedge clock);
  endtask

  task automatic test_ignored_start();
    play(8'b00_01_10_11, 0, 1'b1, "ignored_start");
    play(8'b01_11_00_10, 0, 1'b0, "start_after_fim");
    @(negedge clock);
  endtask

  task automatic test_random();
    for (int k = 0; k < 5; k++) begin
      play(8'($urandom), (k == 2) ? 2 : 0, 1'b0, "random");
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end
    @(negedge clock);
  endtask

  task automatic test_abort();
    logic [3:0] el; logic eo, ef; logic [2:0] es; logic [1:0] ei;
    logic [7:0] w;
    w = 8'($urandom);
    indices = w; iniciar = 1'b1;
    @(negedge clock); iniciar = 1'b0;
    for (int t = 1; t <= 6; t++) begin
      exp_at(t, 3, 2, w, el, eo, ef, es, ei);
      n_cmp++; if (leds !== el) begin n_err++; $display("FAIL abort_pre leds t=%0d got %b exp %b", t, leds, el); end
      if (t == 6) abortar = 1'b1;
      @(negedge clock);
    end
    abortar = 1'b0;
    n_cmp++; if (leds !== 4'b0000) begin n_err++; $display("FAIL abort leds got %b exp 0000", leds); end
    n_cmp++; if (ocupado !== 1'b0) begin n_err++; $display("FAIL abort ocupado got %b exp 0", ocupado); end
    n_cmp++; if (db_item !== 2'd0) begin n_err++; $display("FAIL abort db_item got %0d exp 0", db_item); end
    n_cmp++; if (db_estado !== 3'd0) begin n_err++; $display("FAIL abort db_estado got %0d exp 0", db_estado); end
    for (int t = 0; t < 25; t++) begin
      @(negedge clock);
      n_cmp++; if ({fim, ocupado} !== 2'b00) begin n_err++; $display("FAIL abort_quiet fim/ocupado got %b exp 00", {fim, ocupado}); end
    end
    iniciar = 1'b1; abortar = 1'b1;
    @(negedge clock); iniciar = 1'b0; abortar = 1'b0;
    for (int t = 0; t < 4; t++) begin
      n_cmp++; if ({ocupado, db_estado, leds} !== 8'd0) begin n_err++; $display("FAIL abort_wins got %b exp 0", {ocupado, db_estado, leds}); end
      @(negedge clock);
    end
  endtask

  task automatic test_async_reset(input int at_t);
    logic [3:0] el; logic eo, ef; logic [2:0] es; logic [1:0] ei;
    logic [7:0] w;
    w = 8'($urandom);
    indices = w; iniciar = 1'b1;
    @(negedge clock); iniciar = 1'b0;
    for (int t = 1; t < at_t; t++) @(negedge clock);
    exp_at(at_t, 3, 2, w, el, eo, ef, es, ei);
    n_cmp++; if (db_estado !== es) begin n_err++; $display("FAIL areset_pre db_estado got %0d exp %0d", db_estado, es); end
    #2 reset = 1'b0;
    #1;
    n_cmp++; if ({leds, ocupado, fim, db_estado, db_item} !== 11'd0) begin n_err++; $display("FAIL areset_now t=%0d got %b exp 0", at_t, {leds, ocupado, fim, db_estado, db_item}); end
    @(negedge clock); reset = 1'b1;
    for (int t = 0; t < 10; t++) begin
      @(negedge clock);
      n_cmp++; if ({leds, ocupado, fim, db_estado, db_item} !== 11'd0) begin n_err++; $display("FAIL areset_idle got %b exp 0", {leds, ocupado, fim, db_estado, db_item}); end
    end
  endtask

  task automatic test_default_params();
    logic [3:0] el; logic eo, ef; logic [2:0] es; logic [1:0] ei;
    logic [7:0] w;
    int fim_at;
    w = 8'($urandom);
    fim_at = -1;
    indices_d = w; iniciar_d = 1'b1;
    @(negedge clock); iniciar_d = 1'b0;
    for (int t = 1; t <= 3005; t++) begin
      exp_at(t, 500, 250, w, el, eo, ef, es, ei);
      n_cmp++; if ({leds_d, ocupado_d, fim_d, db_estado_d} !== {el, eo, ef, es}) begin
        n_err++; $display("FAIL default t=%0d leds/oc/fim/st got %b exp %b", t, {leds_d, ocupado_d, fim_d, db_estado_d}, {el, eo, ef, es});
      end
      if (fim_d === 1'b1 && fim_at < 0) fim_at = t;
      indices_d = 8'($urandom);
      @(negedge clock);
    end
    n_cmp++; if (fim_at != 3001) begin n_err++; $display("FAIL default_fim_cycle got %0d exp 3001", fim_at); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_repeat_mask();
    test_ignored_start();
    test_random();
    test_abort();
    test_async_reset(9);
    test_async_reset(7);
    test_basic();
    test_default_params();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/exibidor_sequencia.md
# exibidor_sequencia

Presents the round's 4-item index word to the player as a timed LED sequence. It is the output side of the game's button/compare path: the datapath registers an 8-bit permutation of four 2-bit indices, and this block lights one LED per index, in order, before the player is allowed to answer. The control FSM starts it with a pulse and waits for its end-of-sequence pulse.

## Interface
- `T_ON`, default 500: cycles each LED stays lit; ≥1.
- `T_OFF`, default 250: dark cycles after each LED; ≥1.
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state.
- `iniciar`  in  1  start pulse; sampled only in OCIOSO.
- `indices`  in  8  four 2-bit indices; item k = `indices[2k+1:2k]`, item 0 shown first.
- `abortar`  in  1  synchronous cancel; highest priority after reset.
- `leds`  out  4  one-hot LED drive; `leds[i]`=1 shows index i.
- `ocupado`  out  1  high from the first ACENDE cycle through the FIM cycle.
- `fim`  out  1  one-cycle pulse when the sequence completes normally.
- `db_estado`  out  3  state encoding, for debug.
- `db_item`  out  2  item currently shown.

## Operation
- States and encodings: OCIOSO=0, ACENDE=1, APAGA=2, FIM=3.
- In OCIOSO, `iniciar`=1 does the following:
  - latches `indices` into an internal 8-bit register;
  - clears the item counter and the cycle counter;
  - moves to ACENDE.
- ACENDE:
  - `leds` = one-hot decode of the latched item `db_item`.
  - The cycle counter counts T_ON cycles, then moves to APAGA and clears the counter.
- APAGA:
  - `leds`=0; counts T_OFF cycles.
  - If `db_item`=3, moves to FIM.
  - Otherwise increments `db_item` and moves to ACENDE.
- FIM: `fim`=1 for exactly one cycle, then OCIOSO.
- `abortar`=1 in any state:
  - next state is OCIOSO;
  - `leds`=0 and `db_item`=0;
  - no `fim` pulse.
- `iniciar` outside OCIOSO is ignored. A changing `indices` input after latch has no effect.
- Cycle counter width is ceil(log2(max(T_ON,T_OFF))) bits, minimum 1. It compares against T_ON-1 / T_OFF-1 and never wraps.
- Item counter is 2 bits and saturates logically at 3 via the FIM transition; it never wraps to 0 mid-sequence.
- Repeated indices (e.g. 8'h00) are legal. The same LED relights after each dark gap.
- All outputs are registered or decoded purely from registered state; no combinational path from `indices` to `leds`.
- Reset values: state OCIOSO; `leds`=0; `ocupado`=0; `fim`=0; `db_estado`=0; `db_item`=0; latched word 0.

## Timing
- `iniciar` is sampled high at edge E0.
- `leds` are valid and `ocupado`=1 from the cycle after E0.
- Item k's LED is lit for cycles [1+k·(T_ON+T_OFF), k·(T_ON+T_OFF)+T_ON] after E0, inclusive.
- `fim` is high in cycle 4·(T_ON+T_OFF)+1 after E0. `ocupado` drops the following cycle.
- Total busy time is 4·(T_ON+T_OFF)+1 cycles.
- `iniciar` in the same cycle `fim` is high is ignored, because the block is not yet in OCIOSO. It is accepted one cycle later.
- `abortar` and `iniciar` high together in OCIOSO: abort wins and the block stays idle.
- `reset` asserted mid-sequence clears `leds` immediately and asynchronously. After release the block idles until a new `iniciar`.

## Test plan
Benches run with T_ON=3 and T_OFF=2.

1. **Basic sequence.** Reset, then `indices`=8'b11_10_01_00 and `iniciar` pulse.
   - `leds` = 0001 ×3, 0000 ×2, 0010 ×3, 0000 ×2, 0100 ×3, 0000 ×2, 1000 ×3, 0000 ×2.
   - Then `fim`=1 in cycle 21 and `ocupado`=0 in cycle 22.
2. **Repeated index and input masking.** `indices`=8'h00.
   - LED 0001 lights 4 times with 2-cycle gaps.
   - Changing `indices` to 8'hFF during the sequence has no effect.
3. **Ignored start.** `iniciar` re-pulsed at cycle 5 and again during the `fim` cycle.
   - Neither pulse restarts or extends the sequence.
   - A pulse the cycle after `fim` starts a new sequence.
4. **Abort.** `abortar` in the second ACENDE.
   - Next cycle: `leds`=0, `ocupado`=0, `db_item`=0, `db_estado`=0.
   - `fim` never pulses.
5. **Async reset.** Drive `reset` low mid-APAGA, off a clock edge.
   - Outputs clear immediately.
   - After release, no activity until `iniciar`.
6. **Default parameters.** T_ON=500, T_OFF=250.
   - `fim` is at cycle 3001 after start.
   - The counter does not overflow or wrap.
